// File: rtl/flag_sched_ctrl.sv
// flag_sched_ctrl: run/stop controller for a programmable clock-enable pulse.
// Emits a one-cycle clk_flag every div_act cycles, either for a finite burst
// or continuously until stop. Config arrives over a valid/ready port. While
// running, new config is held in a one-deep shadow and applied at a period
// wrap, so a period is never cut short.
// Optional feature macro: FLAG_SCHED_CLKOUT_EN adds a ~50% duty clk_out.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; config writes go straight to active
// ST_RUN  | counting periods, issuing clk_flag; config goes to shadow
// ST_DONE | finite burst finished; pulse done for one cycle
module flag_sched_ctrl #(
  parameter int CNT_W       = 8,
  parameter int BURST_W     = 8,
  parameter int DIV_DEFAULT = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  output logic               clk_flag,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] flag_cnt
`ifdef FLAG_SCHED_CLKOUT_EN
  ,
  output logic               clk_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   div_act;
  logic [CNT_W-1:0]   div_shd;
  logic [CNT_W-1:0]   div_clamped;
  logic [BURST_W-1:0] burst_act;
  logic [BURST_W-1:0] burst_shd;
  logic [BURST_W-1:0] flag_inc;
  logic               pend;
  logic               cfg_xfer;
  logic               wrap;
  logic               burst_end;

  // Ratios below 2 cannot produce a distinct single-cycle pulse, so clamp them.
  assign div_clamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
  assign cfg_ready   = (state == ST_RUN) ? !pend : 1'b1;
  assign cfg_xfer    = cfg_valid & cfg_ready;
  assign wrap        = (cnt == div_act - CNT_W'(1));
  assign flag_inc    = (flag_cnt == '1) ? flag_cnt : flag_cnt + BURST_W'(1);
  assign burst_end   = (burst_act != '0) && (flag_inc == burst_act);

  // Main sequencer: state, period counter, config registers and pulse outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      flag_cnt  <= '0;
      clk_flag  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      pend      <= 1'b0;
      div_act   <= CNT_W'(DIV_DEFAULT);
      burst_act <= '0;
      div_shd   <= '0;
      burst_shd <= '0;
    end else begin
      clk_flag <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_xfer) begin
            div_act   <= div_clamped;
            burst_act <= cfg_burst;
          end
          if (start && !stop) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            flag_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (cfg_xfer) begin
            div_shd   <= div_clamped;
            burst_shd <= cfg_burst;
            pend      <= 1'b1;
          end
          if (stop) begin
            // Abort wins over a coincident wrap; flag count is kept for readback.
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (wrap) begin
            cnt      <= '0;
            clk_flag <= 1'b1;
            flag_cnt <= flag_inc;
            if (pend) begin
              div_act   <= div_shd;
              burst_act <= burst_shd;
              pend      <= 1'b0;
            end
            if (burst_end) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (cfg_xfer) begin
            div_act   <= div_clamped;
            burst_act <= cfg_burst;
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FLAG_SCHED_CLKOUT_EN
  // Divided clock: rises at each wrap, falls at the half-period point.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_out <= 1'b0;
    end else if (state != ST_RUN || stop) begin
      clk_out <= 1'b0;
    end else if (wrap) begin
      clk_out <= !burst_end;
    end else if (cnt == (div_act >> 1) - CNT_W'(1)) begin
      clk_out <= 1'b0;
    end
  end
`endif

endmodule
